// File: rtl/hb_pkg.sv
// Hummingbird-1 shared definitions: S-boxes, linear mixing, FSM state enum and sizing constants.
package hb_pkg;
  localparam int W      = 16;
  localparam int ROUNDS = 4;
  localparam int STAGES = 4;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} hb_state_e;

  localparam logic [3:0] HB_SBOX1 [16] = '{4'h8, 4'h6, 4'h5, 4'hF, 4'h1, 4'hC, 4'hA, 4'h9,
                                           4'hE, 4'hB, 4'h2, 4'h4, 4'h7, 4'h0, 4'hD, 4'h3};
  localparam logic [3:0] HB_SBOX2 [16] = '{4'h0, 4'h7, 4'hE, 4'h1, 4'h5, 4'hB, 4'h8, 4'h2,
                                           4'h3, 4'hA, 4'hD, 4'h6, 4'hF, 4'hC, 4'h4, 4'h9};
  localparam logic [3:0] HB_SBOX3 [16] = '{4'h2, 4'hE, 4'hF, 4'h5, 4'hC, 4'h1, 4'h9, 4'hA,
                                           4'hB, 4'h4, 4'h6, 4'h8, 4'h0, 4'h7, 4'h3, 4'hD};
  localparam logic [3:0] HB_SBOX4 [16] = '{4'h0, 4'h7, 4'h3, 4'h4, 4'hC, 4'h1, 4'hA, 4'hF,
                                           4'hD, 4'hE, 4'h6, 4'hB, 4'h2, 4'h8, 4'h9, 4'h5};

  // L(x) = x ^ (x <<< 6) ^ (x <<< 10)
  function automatic logic [W-1:0] hb_lmix(input logic [W-1:0] x);
    return x ^ {x[9:0], x[15:10]} ^ {x[5:0], x[15:6]};
  endfunction
endpackage

// File: rtl/hb_wd16_round.sv
// One combinational WD16 round: y = L(S(x ^ k)).
module hb_wd16_round
  import hb_pkg::*;
(
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] k_i,
  output logic [W-1:0] y_o
);
  logic [W-1:0] t;
  logic [W-1:0] s;

  assign t   = x_i ^ k_i;
  assign s   = {HB_SBOX4[t[15:12]], HB_SBOX3[t[11:8]], HB_SBOX2[t[7:4]], HB_SBOX1[t[3:0]]};
  assign y_o = hb_lmix(s);
endmodule

// File: rtl/hb_encrypt_core.sv
// Hummingbird-1 encryption datapath: four cascaded WD16 permutations, iterated per clock.
// HB_ROUND_UNROLL_EN chains two rounds per edge, halving latency with identical results.
module hb_encrypt_core
  import hb_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      ready,
  input  logic [W-1:0]              plaintext,
  input  logic [W-1:0]              rs1,
  input  logic [W-1:0]              rs2,
  input  logic [W-1:0]              rs3,
  input  logic [W-1:0]              rs4,
  input  logic [STAGES*ROUNDS*W-1:0] key,
  output logic [W-1:0]              enc1_out,
  output logic [W-1:0]              enc2_out,
  output logic [W-1:0]              enc3_out,
  output logic [W-1:0]              enc_data_out,
  output logic                      data_rdy
);
  hb_state_e                             state_q, state_d;
  logic [1:0]                            stage_q, stage_d, round_q, round_d;
  logic [W-1:0]                          x_q, x_d;
  logic [STAGES-1:0][ROUNDS-1:0][W-1:0]  key_q, key_d;
  logic [2:0][W-1:0]                     rs_q, rs_d;
  logic [STAGES-1:0][W-1:0]              enc_q, enc_d;
  logic                                  rdy_q, rdy_d;
  logic [W-1:0]                          r1_out, step_out, stage_out;
  logic                                  last_round, accept;

  hb_wd16_round u_rnd0 (.x_i(x_q), .k_i(key_q[stage_q][round_q]), .y_o(r1_out));

`ifdef HB_ROUND_UNROLL_EN
  localparam logic [1:0] RSTEP = 2'd2;
  logic [W-1:0] r2_out;
  hb_wd16_round u_rnd1 (.x_i(r1_out), .k_i(key_q[stage_q][round_q | 2'd1]), .y_o(r2_out));
  assign step_out   = r2_out;
  assign last_round = (round_q == 2'd2);
`else
  localparam logic [1:0] RSTEP = 2'd1;
  assign step_out   = r1_out;
  assign last_round = (round_q == 2'd3);
`endif

  // Whitening with k_0 ^ k_2 closes each stage
  assign stage_out = step_out ^ key_q[stage_q][0] ^ key_q[stage_q][2];
  assign accept    = start & ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      stage_q <= '0;
      round_q <= '0;
      x_q     <= '0;
      key_q   <= '0;
      rs_q    <= '0;
      enc_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      round_q <= round_d;
      x_q     <= x_d;
      key_q   <= key_d;
      rs_q    <= rs_d;
      enc_q   <= enc_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = ROUND;
      ROUND:      if (last_round && stage_q == 2'd3) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    stage_d = stage_q;
    round_d = round_q;
    x_d     = x_q;
    key_d   = key_q;
    rs_d    = rs_q;
    enc_d   = enc_q;
    rdy_d   = 1'b0;
    if (accept) begin
      key_d   = key;
      rs_d    = {rs4, rs3, rs2};
      x_d     = plaintext + rs1;
      stage_d = 2'd0;
      round_d = 2'd0;
    end else if (state_q == ROUND) begin
      if (last_round) begin
        enc_d[stage_q] = stage_out;
        if (stage_q == 2'd3) begin
          rdy_d = 1'b1;
        end else begin
          x_d     = stage_out + rs_q[stage_q];
          stage_d = stage_q + 2'd1;
          round_d = 2'd0;
        end
      end else begin
        x_d     = step_out;
        round_d = round_q + RSTEP;
      end
    end
  end

  always_comb begin
    ready        = (state_q != ROUND);
    data_rdy     = rdy_q;
    enc1_out     = enc_q[0];
    enc2_out     = enc_q[1];
    enc3_out     = enc_q[2];
    enc_data_out = enc_q[3];
  end
endmodule
